// File: rtl/bkt_lvl_scan_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : bkt_lvl_scan_ctrl_if
// Purpose  : Bundles the request, level-state and result signals of the
//            backtrack level scan controller.
// Ports    : master - requester side (drives start/abort/level-state inputs,
//                     observes results)
//            slave  - controller side (bkt_lvl_scan_ctrl)
// Signals  : start_i, abort_i, max_lvl_i, cur_bin_num_i, has_bkt_i, dcd_bin_i
//            busy_o, apply_bkt_o, bkt_lvl_o, bkt_bin_o, bkt_local_o, unsat_o,
//            done_o, cycle_cnt_o
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bkt_lvl_scan_ctrl_if #(
  parameter int NUM_LVLS  = 8,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_BIN = 10
);
  // Request / level-state side
  logic                          start_i;
  logic                          abort_i;
  logic [WIDTH_LVL-1:0]          max_lvl_i;
  logic [WIDTH_BIN-1:0]          cur_bin_num_i;
  logic [NUM_LVLS-1:0]           has_bkt_i;
  logic [WIDTH_BIN*NUM_LVLS-1:0] dcd_bin_i;

  // Result side
  logic                          busy_o;
  logic                          apply_bkt_o;
  logic [WIDTH_LVL-1:0]          bkt_lvl_o;
  logic [WIDTH_BIN-1:0]          bkt_bin_o;
  logic                          bkt_local_o;
  logic                          unsat_o;
  logic                          done_o;
  logic [15:0]                   cycle_cnt_o;

  modport master (
    output start_i,
    output abort_i,
    output max_lvl_i,
    output cur_bin_num_i,
    output has_bkt_i,
    output dcd_bin_i,
    input  busy_o,
    input  apply_bkt_o,
    input  bkt_lvl_o,
    input  bkt_bin_o,
    input  bkt_local_o,
    input  unsat_o,
    input  done_o,
    input  cycle_cnt_o
  );

  modport slave (
    input  start_i,
    input  abort_i,
    input  max_lvl_i,
    input  cur_bin_num_i,
    input  has_bkt_i,
    input  dcd_bin_i,
    output busy_o,
    output apply_bkt_o,
    output bkt_lvl_o,
    output bkt_bin_o,
    output bkt_local_o,
    output unsat_o,
    output done_o,
    output cycle_cnt_o
  );

endinterface : bkt_lvl_scan_ctrl_if

`default_nettype wire

// File: rtl/bkt_lvl_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : bkt_lvl_scan_ctrl
// Purpose  : Conflict-driven backtrack sequencer. Walks the level-state array
//            downward from the requested maximum level, one level per cycle,
//            and reports the highest level whose decision is not yet
//            backtracked together with its deciding bin, followed by a single
//            apply-backtrack strobe. Reports UNSAT if levels max..1 are all
//            already backtracked.
// Ports    : clk  - clock
//            rst  - asynchronous, active-high reset
//            bus  - bkt_lvl_scan_ctrl_if.slave (request inputs, level-state
//                   inputs, registered results and strobes)
// Config   : BKT_SCAN_CNT_EN - when defined, cycle_cnt_o counts SCAN cycles of
//                   the last search (saturating at 16'hFFFF); otherwise it is
//                   tied to zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bkt_lvl_scan_ctrl #(
  parameter int NUM_LVLS  = 8,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_BIN = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bkt_lvl_scan_ctrl_if.slave    bus
);

  localparam int c_PTR_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_PTR_W-1:0]     r_ptr;
  logic                   r_busy;
  logic                   r_apply;
  logic                   r_done;
  logic                   r_unsat;
  logic                   r_local;
  logic [WIDTH_LVL-1:0]   r_lvl;
  logic [WIDTH_BIN-1:0]   r_bin;

  logic [WIDTH_BIN-1:0]   w_dcd_bin [NUM_LVLS];
  logic [c_PTR_W-1:0]     w_start_ptr;
  logic [WIDTH_BIN-1:0]   w_hit_bin;
  logic                   w_start_ok;

  // Unpack the flat deciding-bin bus into one entry per level slot.
  for (genvar gi = 0; gi < NUM_LVLS; gi++) begin : g_unpack
    assign w_dcd_bin[gi] = bus.dcd_bin_i[gi*WIDTH_BIN +: WIDTH_BIN];
  end

  // Requests beyond the array are clamped to the top slot silently.
  assign w_start_ptr = (bus.max_lvl_i >= WIDTH_LVL'(NUM_LVLS))
                     ? c_PTR_W'(NUM_LVLS - 1)
                     : bus.max_lvl_i[c_PTR_W-1:0];

  assign w_hit_bin  = w_dcd_bin[r_ptr];
  assign w_start_ok = (r_state == ST_IDLE) && bus.start_i;

  //----------------------------------------------------------------------------
  // Sequencer. All outputs are registered here so that no input reaches an
  // output combinationally. apply/done are one-cycle strobes: they default low
  // each cycle and are raised only on the transition into APPLY/DONE.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_apply <= 1'b0;
      r_done  <= 1'b0;
      r_unsat <= 1'b0;
      r_local <= 1'b0;
      r_lvl   <= '0;
      r_bin   <= '0;
    end else begin
      r_apply <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_ptr   <= w_start_ptr;
            r_unsat <= 1'b0;
            r_local <= 1'b0;
            r_lvl   <= '0;
            r_bin   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (bus.abort_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_ptr == '0) begin
            // Root level reached without finding an open decision.
            r_unsat <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (!bus.has_bkt_i[r_ptr]) begin
            r_lvl   <= WIDTH_LVL'(r_ptr);
            r_bin   <= w_hit_bin;
            r_local <= (w_hit_bin == bus.cur_bin_num_i);
            r_apply <= 1'b1;
            r_state <= ST_APPLY;
          end else begin
            r_ptr   <= r_ptr - 1'b1;
          end
        end

        ST_APPLY: begin
          r_busy <= 1'b0;
          if (bus.abort_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // A start seen here is dropped, not queued.
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BKT_SCAN_CNT_EN
  //----------------------------------------------------------------------------
  // Scan-cycle counter: cleared by an accepted start, counts every cycle spent
  // in SCAN and saturates instead of wrapping. Holds after the search ends.
  //----------------------------------------------------------------------------
  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
    end else if ((r_state == ST_SCAN) && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.cycle_cnt_o = r_cnt;
`else
  logic w_unused_start_ok;
  assign w_unused_start_ok = w_start_ok;
  assign bus.cycle_cnt_o   = 16'd0;
`endif

  assign bus.busy_o      = r_busy;
  assign bus.apply_bkt_o = r_apply;
  assign bus.done_o      = r_done;
  assign bus.unsat_o     = r_unsat;
  assign bus.bkt_local_o = r_local;
  assign bus.bkt_lvl_o   = r_lvl;
  assign bus.bkt_bin_o   = r_bin;

endmodule : bkt_lvl_scan_ctrl

`default_nettype wire
